// File: rtl/countdown_pkg.sv
// countdown_pkg: shared states, field codes, limits and wrap helper for hms_countdown.
package countdown_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SET, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    localparam logic [1:0] FIELD_NONE  = 2'd0;
    localparam logic [1:0] FIELD_SECS  = 2'd1;
    localparam logic [1:0] FIELD_MINS  = 2'd2;
    localparam logic [1:0] FIELD_HOURS = 2'd3;

    localparam logic [5:0] SECS_MAX  = 6'd59;
    localparam logic [5:0] MINS_MAX  = 6'd59;
    localparam logic [5:0] HOURS_MAX = 6'd23;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV while run is high, freezing otherwise.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart)
            r_cnt <= '0;
        else if (run)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/hms_countdown.sv
// hms_countdown: programmable h:m:s countdown with set/run/pause/done control.
// COUNTDOWN_AUTORELOAD_EN: reaching zero reloads the preset and keeps running.
module hms_countdown
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pause,
    input  logic       set_mode,
    input  logic       inc,
    input  logic       clear,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic [5:0] hours,
    output logic [1:0] field_sel,
    output logic       running,
    output logic       done
);
    state_t     r_state;
    logic [5:0] r_secs, r_mins, r_hours;
    logic [5:0] r_ps_s, r_ps_m, r_ps_h;
    logic [1:0] r_field;
    logic       r_running, r_done;

    logic       w_clr, w_set, w_sp, w_inc, w_ps_zero, w_last, w_tick, w_run, w_restart;
    logic [5:0] w_ns_s, w_ns_m, w_ns_h, w_dec_s, w_dec_m, w_dec_h;

    // Only the highest-priority pulse is allowed to act.
    assign w_clr = clear;
    assign w_set = set_mode & ~clear;
    assign w_sp  = start_pause & ~clear & ~set_mode;
    assign w_inc = inc & ~clear & ~set_mode & ~start_pause;

    assign w_ps_zero = (r_ps_s == 6'd0) && (r_ps_m == 6'd0) && (r_ps_h == 6'd0);
    assign w_last    = (r_hours == 6'd0) && (r_mins == 6'd0) && (r_secs == 6'd1);

    always_comb begin
        w_ns_s = (r_state == ST_IDLE && w_clr) ? 6'd0 :
                 (r_state == ST_SET && w_inc && r_field == FIELD_SECS) ? inc_wrap(r_ps_s, SECS_MAX) : r_ps_s;
        w_ns_m = (r_state == ST_IDLE && w_clr) ? 6'd0 :
                 (r_state == ST_SET && w_inc && r_field == FIELD_MINS) ? inc_wrap(r_ps_m, MINS_MAX) : r_ps_m;
        w_ns_h = (r_state == ST_IDLE && w_clr) ? 6'd0 :
                 (r_state == ST_SET && w_inc && r_field == FIELD_HOURS) ? inc_wrap(r_ps_h, HOURS_MAX) : r_ps_h;
        w_dec_s = (r_secs == 6'd0) ? SECS_MAX : r_secs - 6'd1;
        w_dec_m = (r_secs != 6'd0) ? r_mins : (r_mins == 6'd0) ? MINS_MAX : r_mins - 6'd1;
        w_dec_h = (r_secs == 6'd0 && r_mins == 6'd0) ? r_hours - 6'd1 : r_hours;
    end

    // Pausing or aborting freezes the prescaler in that same cycle.
    assign w_run     = (r_state == ST_RUN) && !w_sp && !w_clr;
    assign w_restart = (r_state == ST_IDLE) && w_sp && !w_ps_zero;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .run    (w_run),
        .restart(w_restart),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            {r_secs, r_mins, r_hours} <= '0;
            {r_ps_s, r_ps_m, r_ps_h}  <= '0;
            r_field   <= FIELD_NONE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ps_s <= w_ns_s;
            r_ps_m <= w_ns_m;
            r_ps_h <= w_ns_h;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    {r_secs, r_mins, r_hours} <= {w_ns_s, w_ns_m, w_ns_h};
                    if (w_set) begin
                        r_state <= ST_SET;
                        r_field <= FIELD_SECS;
                    end else if (w_restart) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_SET: begin
                    {r_secs, r_mins, r_hours} <= {w_ns_s, w_ns_m, w_ns_h};
                    if (w_clr || (w_set && r_field == FIELD_HOURS)) begin
                        r_state <= ST_IDLE;
                        r_field <= FIELD_NONE;
                    end else if (w_set)
                        r_field <= r_field + 2'd1;
                end
                ST_RUN: begin
                    if (w_clr) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                        {r_secs, r_mins, r_hours} <= {r_ps_s, r_ps_m, r_ps_h};
                    end else if (w_sp) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick && w_last) begin
                        r_done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        {r_secs, r_mins, r_hours} <= {r_ps_s, r_ps_m, r_ps_h};
`else
                        {r_secs, r_mins, r_hours} <= '0;
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
`endif
                    end else if (w_tick)
                        {r_secs, r_mins, r_hours} <= {w_dec_s, w_dec_m, w_dec_h};
                end
                ST_PAUSE: begin
                    if (w_clr) begin
                        r_state <= ST_IDLE;
                        {r_secs, r_mins, r_hours} <= {r_ps_s, r_ps_m, r_ps_h};
                    end else if (w_sp) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_clr || w_sp) begin
                        r_state <= ST_IDLE;
                        {r_secs, r_mins, r_hours} <= {r_ps_s, r_ps_m, r_ps_h};
                    end else
                        r_done <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign secs      = r_secs;
    assign mins      = r_mins;
    assign hours     = r_hours;
    assign field_sel = r_field;
    assign running   = r_running;
    assign done      = r_done;
endmodule

// File: tb/tb_hms_countdown.sv
// tb_hms_countdown: directed checks of hms_countdown with TICK_DIV = 4.
module tb_hms_countdown;
    logic       clk = 1'b0, reset = 1'b1;
    logic       start_pause = 1'b0, set_mode = 1'b0, inc = 1'b0, clear = 1'b0;
    logic [5:0] secs, mins, hours;
    logic [1:0] field_sel;
    logic       running, done;
    int         n_cmp = 0, n_bad = 0;

    hms_countdown #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start_pause(start_pause), .set_mode(set_mode),
        .inc(inc), .clear(clear), .secs(secs), .mins(mins), .hours(hours),
        .field_sel(field_sel), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic c, input logic s, input logic p, input logic n);
        clear = c; set_mode = s; start_pause = p; inc = n;
        cyc(1);
        clear = 0; set_mode = 0; start_pause = 0; inc = 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_hms(input string tag, input int h, input int m, input int s);
        chk(tag, {18'd0, hours, mins, secs}, (h << 12) | (m << 6) | s);
    endtask

    initial begin
        cyc(2);
        reset = 0;
        chk_hms("reset_count", 0, 0, 0);
        chk("reset_field", field_sel, 0);
        chk("reset_running", running, 0);
        chk("reset_done", done, 0);

        pulse(0, 1, 0, 0);
        chk("prog_field1", field_sel, 1);
        for (int i = 0; i < 3; i++) pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        chk("prog_field2", field_sel, 2);
        pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        chk("prog_field3", field_sel, 3);
        pulse(0, 1, 0, 0);
        chk("prog_field0", field_sel, 0);
        chk_hms("prog_preset", 0, 1, 3);

        pulse(1, 0, 0, 0);
        chk_hms("idle_clear", 0, 0, 0);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0); pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("start_running", running, 1);
        cyc(3);
        chk_hms("before_tick", 0, 1, 0);
        cyc(1);
        chk_hms("first_tick", 0, 0, 59);
        chk("first_tick_running", running, 1);

        pulse(1, 0, 1, 0);
        chk_hms("clr_sp_reload", 0, 1, 0);
        chk("clr_sp_running", running, 0);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);

        pulse(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        chk_hms("preset_1h", 1, 0, 0);
        pulse(0, 0, 1, 0);
        cyc(4);
        chk_hms("double_borrow", 0, 59, 59);
        pulse(1, 0, 0, 0);
        chk_hms("run_clear_reload", 1, 0, 0);

        for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
        for (int i = 0; i < 22; i++) pulse(0, 0, 0, 1);
        chk("hours_23", hours, 23);
        pulse(0, 0, 0, 1);
        chk("hours_wrap", hours, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        cyc(5);
        chk("zero_start_running", running, 0);
        chk_hms("zero_start_count", 0, 0, 0);

        pulse(0, 1, 0, 0);
        for (int i = 0; i < 59; i++) pulse(0, 0, 0, 1);
        chk("secs_59", secs, 59);
        pulse(0, 0, 0, 1);
        chk("secs_wrap", secs, 0);
        pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        chk("set_ignores_start", running, 0);
        pulse(1, 0, 0, 0);
        chk("set_clear_field", field_sel, 0);
        chk_hms("set_clear_keeps", 0, 0, 2);

        pulse(0, 0, 1, 0);
        cyc(4);
        chk_hms("pause_pre", 0, 0, 1);
        cyc(1);
        pulse(0, 0, 1, 0);
        chk("paused_running", running, 0);
        cyc(20);
        chk_hms("paused_hold", 0, 0, 1);
        pulse(0, 0, 1, 0);
        chk("resume_running", running, 1);
        cyc(2);
        chk_hms("resume_remainder", 0, 0, 1);
        cyc(1);
        chk("end_done", done, 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
        chk_hms("end_reload", 0, 0, 2);
        chk("end_running", running, 1);
        cyc(1);
        chk("done_pulse_end", done, 0);
        chk("still_running", running, 1);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
`else
        chk_hms("end_zero", 0, 0, 0);
        chk("end_running", running, 0);
        cyc(3);
        chk("done_held", done, 1);
        chk_hms("done_count_zero", 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("done_ack", done, 0);
        chk_hms("done_ack_reload", 0, 0, 2);
`endif
        chk("back_idle_running", running, 0);

        pulse(0, 0, 1, 0);
        cyc(5);
        chk_hms("pre_reset_count", 0, 0, 1);
        reset = 1;
        cyc(1);
        chk_hms("mid_reset_count", 0, 0, 0);
        chk("mid_reset_running", running, 0);
        chk("mid_reset_field", field_sel, 0);
        chk("mid_reset_done", done, 0);
        reset = 0;
        pulse(0, 0, 1, 0);
        chk("reset_preset_zero", running, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hms_countdown.md
# hms_countdown

Countdown timer core for the CountdownTimer design. Holds a user-programmable hours/minutes/seconds preset, counts it down to zero at a 1 Hz tick derived from the system clock, and raises a done indication. It sits directly upstream of the HMS seven-segment display stage: its `secs`, `mins` and `hours` outputs feed that stage's binary inputs, and `field_sel` feeds its 2-bit `enable` input.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count-down step (1 Hz at 50 MHz).
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_pause`  in  1  single-cycle pulse, already debounced and synchronized upstream; starts, pauses, resumes, or acknowledges done.
- `set_mode`  in  1  single-cycle pulse; enters set mode and advances the selected field.
- `inc`  in  1  single-cycle pulse; increments the selected preset field.
- `clear`  in  1  single-cycle pulse; aborts the count or zeroes the preset.
- `secs`  out  6  current seconds, 0–59.
- `mins`  out  6  current minutes, 0–59.
- `hours`  out  6  current hours, 0–23.
- `field_sel`  out  2  field under edit: 0 none, 1 secs, 2 mins, 3 hours.
- `running`  out  1  high in RUN.
- `done`  out  1  done indication; see Configuration.

## Operation
- States are IDLE, SET, RUN, PAUSE and DONE.
- Reset: state IDLE; preset = 0:00:00; count = 0; `field_sel` = 0; `running` = 0; `done` = 0; prescaler = 0.
- Input priority when pulses coincide: `clear` > `set_mode` > `start_pause` > `inc`. Only the highest-priority pulse acts in a cycle.
- IDLE:
  - count mirrors preset.
  - `set_mode` → SET with `field_sel` = 1.
  - `start_pause` with preset ≠ 0 → RUN and prescaler cleared. With preset = 0 the pulse is ignored.
  - `clear` zeroes preset and count.
- SET:
  - `set_mode` advances `field_sel` 1→2→3. From 3, `set_mode` → IDLE with `field_sel` = 0.
  - `inc` increments the selected preset field. Secs and mins wrap 59→0; hours wraps 23→0. There is no carry between fields.
  - count mirrors preset.
  - `start_pause` is ignored.
  - `clear` → IDLE with preset unchanged and `field_sel` = 0.
- RUN:
  - On each tick, decrement with borrow: secs 0→59 borrows from mins; mins 0→59 borrows from hours.
  - The decrement that reaches 0:00:00 triggers the end-of-count action (see Configuration).
  - `start_pause` → PAUSE.
  - `clear` → IDLE and count reloads preset.
  - `inc` and `set_mode` are ignored.
- PAUSE:
  - Count and prescaler are frozen.
  - `start_pause` → RUN; the prescaler resumes from its frozen value.
  - `clear` → IDLE with reload.
- DONE:
  - count holds 0.
  - `start_pause` or `clear` → IDLE with reload.
- Arithmetic: all fields are 6-bit unsigned. The count can never leave its legal range.

## Timing
- Prescaler counts 0..TICK_DIV-1 in RUN only. Tick is asserted in the cycle the prescaler equals TICK_DIV-1, and the prescaler wraps to 0 in that cycle.
- First decrement occurs TICK_DIV cycles after the start-pulse cycle. Outputs update on the clock edge ending the tick cycle.
- State transitions take effect on the edge after the input pulse. Outputs are registered, so response latency is 1 cycle.
- `reset` mid-count overrides everything on the next edge and restores the reset values.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`.
- Defined:
  - Reaching zero reloads count from preset and stays in RUN.
  - The prescaler continues without restart.
  - `done` is a 1-cycle pulse, coincident with the reload edge.
  - DONE is unreachable.
- Undefined:
  - Reaching zero → DONE with count 0:00:00.
  - `done` is held high for the whole of DONE.

## Structure
- Package `countdown_pkg` holds:
  - the state enum;
  - field-select codes FIELD_NONE/SECS/MINS/HOURS;
  - constants SECS_MAX = 59, MINS_MAX = 59, HOURS_MAX = 23.
- Sub-module `tick_prescaler`:
  - parameter TICK_DIV;
  - inputs `clk`, `reset`, `run`, `restart`;
  - output `tick`;
  - counter freezes when `run` is low; `restart` zeroes it.

## Test plan
Bench uses TICK_DIV = 4.
- Program the preset: `set_mode`, `inc` ×3, `set_mode`, `inc` ×1, `set_mode` ×2. Required: preset 0:01:03 and `field_sel` sequence 1, 2, 3, 0.
- Preset 0:01:00, `start_pause`. Required: 4 cycles later count = 0:00:59; `running` = 1.
- Preset 1:00:00, one tick. Required: count 0:59:59 (double borrow).
- Preset 0:00:02, run, pause after the first tick for 20 cycles, then resume. Required:
  - count holds 0:00:01 while paused;
  - reaches 0 exactly 4 cycles of RUN later, counting the prescaler's frozen remainder;
  - without the macro: `done` stays high until `start_pause`, then IDLE with count 0:00:02;
  - with the macro: 1-cycle `done` pulse and count back to 0:00:02 still in RUN.
- `clear` and `start_pause` in the same cycle during RUN. Required: IDLE, count = preset, `running` = 0. `start_pause` with preset 0:00:00 in IDLE. Required: stays IDLE.
- Inc wrap: hours at 23 + `inc` → 0, secs at 59 + `inc` → 0. `reset` asserted mid-RUN: all outputs return to reset values next edge.
